// File: rtl/apb_req_arbiter.sv
// apb_req_arbiter
//   Three-requester round-robin front end for a downstream APB FSM controller.
//   One transaction is in flight at a time: ARB grants, ISSUE hands the
//   request to the controller, WAIT holds the fields while the controller
//   runs SETUP/ACCESS, RESP returns a one-cycle response pulse to the winner.
//
//   Optional feature: define APB_ARB_WDOG_EN to add a watchdog that ends a
//   stuck ISSUE/WAIT after WDOG_CYCLES cycles with resp_err = 2'b11.
//
// Ports
//   Pclk, Presetn                 clock, async active-low reset
//   req_valid/addr/wdata/write/sel per-requester request, requester i packed
//                                 at [32i+31:32i] (addr/wdata), [3i+2:3i] (sel)
//   req_ready                     one-hot grant pulse (combinational in ARB)
//   resp_valid/rdata/err          one-hot response pulse + shared data/error
//   p_req_*                       request port to the controller
//   p_resp_*                      response port from the controller
//   busy                          high outside ARB
//   grant_id                      current or last granted requester
module apb_req_arbiter #(
  parameter int unsigned WDOG_CYCLES = 16
) (
  input  logic        Pclk,
  input  logic        Presetn,
  input  logic [2:0]  req_valid,
  input  logic [95:0] req_addr,
  input  logic [95:0] req_wdata,
  input  logic [2:0]  req_write,
  input  logic [8:0]  req_sel,
  output logic [2:0]  req_ready,
  output logic [2:0]  resp_valid,
  output logic [31:0] resp_rdata,
  output logic [1:0]  resp_err,
  output logic        p_req_valid,
  output logic [31:0] p_req_addr,
  output logic [31:0] p_req_wdata,
  output logic        p_req_write,
  output logic [2:0]  p_req_sel,
  input  logic        p_req_accept,
  input  logic        p_resp_valid,
  input  logic [31:0] p_resp_rdata,
  input  logic [1:0]  p_resp_err,
  output logic        busy,
  output logic [1:0]  grant_id
);

  typedef enum logic [1:0] {ARB, ISSUE, WAIT, RESP} state_t;

  state_t      state_q, state_d;
  logic [1:0]  last_q, last_d;
  logic [1:0]  gid_q, gid_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic        wr_q, wr_d;
  logic [2:0]  sel_q, sel_d;
  logic [31:0] rdata_q, rdata_d;
  logic [1:0]  err_q, err_d;

  logic        win_vld;
  logic [1:0]  win_idx;
  logic [31:0] win_addr, win_wdata;
  logic        win_wr;
  logic [2:0]  win_sel;
  logic        wdog_hit;

  // Round-robin: scan starting one past the last winner, wrapping mod 3.
  always_comb begin
    int idx;
    idx       = 0;
    win_vld   = 1'b0;
    win_idx   = 2'd0;
    win_addr  = '0;
    win_wdata = '0;
    win_wr    = 1'b0;
    win_sel   = '0;
    for (int k = 1; k <= 3; k++) begin
      idx = (int'(last_q) + k) % 3;
      if (!win_vld && req_valid[idx]) begin
        win_vld   = 1'b1;
        win_idx   = 2'(idx);
        win_addr  = req_addr[idx*32 +: 32];
        win_wdata = req_wdata[idx*32 +: 32];
        win_wr    = req_write[idx];
        win_sel   = req_sel[idx*3 +: 3];
      end
    end
  end

`ifdef APB_ARB_WDOG_EN
  logic [7:0] wdog_q, wdog_d;

  // ISSUE is only entered from ARB, so clearing in ARB clears on ISSUE entry.
  always_comb begin
    wdog_d = wdog_q;
    if (state_q == ARB)                          wdog_d = '0;
    else if (state_q == ISSUE || state_q == WAIT) wdog_d = wdog_q + 8'd1;
  end

  always_ff @(posedge Pclk or negedge Presetn)
    if (!Presetn) wdog_q <= '0;
    else          wdog_q <= wdog_d;

  // Fires on the WDOG_CYCLES-th cycle spent in ISSUE/WAIT.
  assign wdog_hit = (wdog_q == 8'(WDOG_CYCLES - 1));
`else
  // No watchdog: constant 0 over the legal parameter range.
  assign wdog_hit = (WDOG_CYCLES == 0);
`endif

  always_comb begin
    state_d     = state_q;
    last_d      = last_q;
    gid_d       = gid_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    wr_d        = wr_q;
    sel_d       = sel_q;
    rdata_d     = rdata_q;
    err_d       = err_q;
    req_ready   = '0;
    resp_valid  = '0;
    p_req_valid = 1'b0;
    unique case (state_q)
      ARB: if (win_vld) begin
        req_ready[win_idx] = 1'b1;
        addr_d  = win_addr;
        wdata_d = win_wdata;
        wr_d    = win_wr;
        sel_d   = win_sel;
        gid_d   = win_idx;
        last_d  = win_idx;
        state_d = ISSUE;
      end
      ISSUE: begin
        p_req_valid = 1'b1;
        // Acceptance is not completion, so a timeout here still wins.
        if (wdog_hit) begin
          rdata_d = '0;
          err_d   = 2'b11;
          state_d = RESP;
        end else if (p_req_accept) begin
          state_d = WAIT;
        end
      end
      WAIT: begin
        if (p_resp_valid) begin
          rdata_d = p_resp_rdata;
          err_d   = p_resp_err;
          state_d = RESP;
        end else if (wdog_hit) begin
          rdata_d = '0;
          err_d   = 2'b11;
          state_d = RESP;
        end
      end
      RESP: begin
        resp_valid[gid_q] = 1'b1;
        state_d           = ARB;
      end
    endcase
    // State is ARB during reset; no grant may be offered then.
    if (!Presetn) req_ready = '0;
  end

  always_ff @(posedge Pclk or negedge Presetn)
    if (!Presetn) begin
      state_q <= ARB;
      last_q  <= 2'd2;
      gid_q   <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      wr_q    <= 1'b0;
      sel_q   <= '0;
      rdata_q <= '0;
      err_q   <= '0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      gid_q   <= gid_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      wr_q    <= wr_d;
      sel_q   <= sel_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end

  assign busy        = (state_q != ARB);
  assign grant_id    = gid_q;
  assign p_req_addr  = addr_q;
  assign p_req_wdata = wdata_q;
  assign p_req_write = wr_q;
  assign p_req_sel   = sel_q;
  // Updated only on the edge entering RESP, so they change together with
  // resp_valid and hold otherwise.
  assign resp_rdata  = rdata_q;
  assign resp_err    = err_q;

endmodule

// File: tb/tb_apb_req_arbiter.sv
// Randomized bench for apb_req_arbiter with a transaction-level reference
// model (round-robin pick, fixed ISSUE/WAIT/RESP timing) and a small
// controller model that accepts and responds after chosen delays.
module tb_apb_req_arbiter;
  logic        Pclk = 1'b0;
  logic        Presetn = 1'b0;
  logic [2:0]  req_valid;
  logic [95:0] req_addr, req_wdata;
  logic [2:0]  req_write;
  logic [8:0]  req_sel;
  logic [2:0]  req_ready, resp_valid;
  logic [31:0] resp_rdata;
  logic [1:0]  resp_err;
  logic        p_req_valid, p_req_write;
  logic [31:0] p_req_addr, p_req_wdata;
  logic [2:0]  p_req_sel;
  logic        p_req_accept = 1'b0;
  logic        p_resp_valid = 1'b0;
  logic [31:0] p_resp_rdata = '0;
  logic [1:0]  p_resp_err = '0;
  logic        busy;
  logic [1:0]  grant_id;

  always #5 Pclk = ~Pclk;

  apb_req_arbiter #(.WDOG_CYCLES(8)) dut (
    .Pclk(Pclk), .Presetn(Presetn),
    .req_valid(req_valid), .req_addr(req_addr), .req_wdata(req_wdata),
    .req_write(req_write), .req_sel(req_sel), .req_ready(req_ready),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
    .p_req_valid(p_req_valid), .p_req_addr(p_req_addr), .p_req_wdata(p_req_wdata),
    .p_req_write(p_req_write), .p_req_sel(p_req_sel), .p_req_accept(p_req_accept),
    .p_resp_valid(p_resp_valid), .p_resp_rdata(p_resp_rdata), .p_resp_err(p_resp_err),
    .busy(busy), .grant_id(grant_id)
  );

  // requester stimulus
  bit          rv[3];
  logic [31:0] ra[3], rw[3];
  bit          rwr[3];
  logic [2:0]  rs[3];

  always_comb begin
    for (int i = 0; i < 3; i++) begin
      req_valid[i]          = rv[i];
      req_addr[i*32 +: 32]  = ra[i];
      req_wdata[i*32 +: 32] = rw[i];
      req_write[i]          = rwr[i];
      req_sel[i*3 +: 3]     = rs[i];
    end
  end

  int total = 0, bad = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // reference model state
  int          cyc = 0, last_g, g_id, grant_cyc, pend_clr;
  logic [31:0] g_addr, g_wdata, exp_rdata, hold_rdata;
  bit          g_wr;
  logic [2:0]  g_sel;
  logic [1:0]  exp_err, hold_err;
  bit          arb_free, issue_pend, ctl_out, resp_due;
  int          acc_cnt, resp_cnt;
  int          oq[$], oc[$];
  // knobs
  bit rnd_req = 0, rnd_dly = 0, stray_en = 0, hold_all = 0, fix_data = 0, lat_chk = 0;

  function automatic int rr_pick(input int last, input bit [2:0] v);
    for (int k = 1; k <= 3; k++) begin
      int i;
      i = (last + k) % 3;
      if (v[i]) return i;
    end
    return -1;
  endfunction

  task automatic model_reset();
    last_g = 2; g_id = 0; g_addr = '0; g_wdata = '0; g_wr = 0; g_sel = '0;
    arb_free = 1; issue_pend = 0; ctl_out = 0; resp_due = 0; pend_clr = -1;
    hold_rdata = '0; hold_err = '0;
  endtask

  // Called at a negedge; returns at the next negedge.
  task automatic tick();
    int w;
    bit resp_now;
    logic [2:0] exp_ready;
    cyc++;
    if (pend_clr >= 0) rv[pend_clr] = 0;
    pend_clr = -1;
    if (rnd_req)
      for (int i = 0; i < 3; i++) begin
        if (!rv[i]) begin
          if ($urandom_range(0, 2) == 0) begin
            rv[i] = 1; ra[i] = $urandom; rw[i] = $urandom;
            rwr[i] = 1'($urandom_range(0, 1)); rs[i] = 3'($urandom_range(0, 7));
          end
        end else if ($urandom_range(0, 15) == 0) rv[i] = 0;
      end
    if (hold_all) begin rv[0] = 1; rv[1] = 1; rv[2] = 1; end
    p_req_accept = 0; p_resp_valid = 0; resp_now = 0;
    if (ctl_out) begin
      resp_cnt--;
      if (resp_cnt == 0) begin
        ctl_out = 0; resp_now = 1; p_resp_valid = 1;
        p_resp_rdata = fix_data ? 32'hDEAD_BEEF : $urandom;
        p_resp_err   = fix_data ? 2'b00 : 2'($urandom_range(0, 2));
        exp_rdata = p_resp_rdata; exp_err = p_resp_err;
      end
    end else if (stray_en && $urandom_range(0, 5) == 0) begin
      p_resp_valid = 1; p_resp_rdata = $urandom; p_resp_err = 2'($urandom_range(0, 3));
    end
    #1;
    w = arb_free ? rr_pick(last_g, {rv[2], rv[1], rv[0]}) : -1;
    exp_ready = (w >= 0) ? 3'(1 << w) : 3'b000;
    for (int i = 0; i < 3; i++) if (req_ready[i]) begin oq.push_back(i); oc.push_back(cyc); end
    chk("req_ready", req_ready, exp_ready);
    chk("resp_valid", resp_valid, resp_due ? 3'(1 << g_id) : 3'b000);
    chk("resp_rdata", resp_rdata, resp_due ? exp_rdata : hold_rdata);
    chk("resp_err", resp_err, resp_due ? exp_err : hold_err);
    chk("p_req_valid", p_req_valid, issue_pend);
    chk("busy", busy, !arb_free);
    chk("grant_id", grant_id, g_id);
    chk("p_req_addr", p_req_addr, g_addr);
    chk("p_req_wdata", p_req_wdata, g_wdata);
    chk("p_req_write", p_req_write, g_wr);
    chk("p_req_sel", p_req_sel, g_sel);
    if (resp_due && lat_chk) chk("latency", cyc - grant_cyc, 4);
    // controller accepts the pending request
    if (issue_pend) begin
      if (acc_cnt == 0) begin
        p_req_accept = 1; issue_pend = 0; ctl_out = 1;
        resp_cnt = rnd_dly ? $urandom_range(1, 3) : 2;
      end else acc_cnt--;
    end
    if (resp_due) begin
      resp_due = 0; arb_free = 1; hold_rdata = exp_rdata; hold_err = exp_err;
    end
    if (resp_now) resp_due = 1;
    if (w >= 0) begin
      arb_free = 0; last_g = w; g_id = w; grant_cyc = cyc;
      g_addr = ra[w]; g_wdata = rw[w]; g_wr = rwr[w]; g_sel = rs[w];
      issue_pend = 1; acc_cnt = rnd_dly ? $urandom_range(0, 2) : 0;
      pend_clr = w;
    end
    @(negedge Pclk);
  endtask

  task automatic do_reset();
    Presetn = 0; p_req_accept = 0; p_resp_valid = 0;
    #1;
    chk("rst_req_ready", req_ready, 0);
    chk("rst_resp_valid", resp_valid, 0);
    chk("rst_resp_rdata", resp_rdata, 0);
    chk("rst_resp_err", resp_err, 0);
    chk("rst_p_req_valid", p_req_valid, 0);
    chk("rst_p_req_addr", p_req_addr, 0);
    chk("rst_p_req_wdata", p_req_wdata, 0);
    chk("rst_p_req_write", p_req_write, 0);
    chk("rst_p_req_sel", p_req_sel, 0);
    chk("rst_busy", busy, 0);
    chk("rst_grant_id", grant_id, 0);
    model_reset();
    repeat (2) @(negedge Pclk);
    Presetn = 1;
  endtask

  initial begin
    for (int i = 0; i < 3; i++) begin rv[i] = 0; ra[i] = '0; rw[i] = '0; rwr[i] = 0; rs[i] = '0; end
    model_reset();
    @(negedge Pclk);
    do_reset();

    // single read from requester 0, idle controller
    fix_data = 1; lat_chk = 1;
    rv[0] = 1; ra[0] = 32'h0000_1000; rs[0] = 3'b001; rwr[0] = 0;
    repeat (7) tick();
    chk("single_rd_data", resp_rdata, 32'hDEAD_BEEF);

    // write from requester 2
    rv[2] = 1; ra[2] = 32'h20; rw[2] = 32'h1234_5678; rs[2] = 3'b100; rwr[2] = 1;
    repeat (7) tick();

    // requester 1 arrives while requester 0 is in WAIT
    rv[0] = 1; ra[0] = 32'h44; rs[0] = 3'b010;
    repeat (3) tick();
    rv[1] = 1; ra[1] = 32'h88; rw[1] = 32'h5a5a; rs[1] = 3'b001; rwr[1] = 1;
    repeat (10) tick();

    // all three held from reset: 0,1,2,0 spaced 5 apart
    do_reset();
    oq.delete(); oc.delete();
    hold_all = 1;
    repeat (17) tick();
    hold_all = 0; rv[0] = 0; rv[1] = 0; rv[2] = 0;
    if (oq.size() >= 4) begin
      chk("rr_g0", oq[0], 0); chk("rr_g1", oq[1], 1);
      chk("rr_g2", oq[2], 2); chk("rr_g3", oq[3], 0);
      for (int i = 0; i < 3; i++) chk("rr_space", oc[i+1] - oc[i], 5);
    end else chk("rr_grant_count", oq.size(), 4);
    repeat (6) tick();

    // reset pulse during WAIT
    rv[0] = 1; ra[0] = 32'h300;
    for (int n = 0; n < 10 && !ctl_out; n++) tick();
    chk("rst_wait_reached", ctl_out, 1);
    tick();
    rv[0] = 1; rv[1] = 1; rv[2] = 1;
    do_reset();
    #1;
    chk("rst_first_grant", req_ready, 3'b001);
    #1;
    repeat (20) tick();
    rv[0] = 0; rv[1] = 0; rv[2] = 0;
    repeat (8) tick();

    // randomized traffic with random controller delays and stray responses
    fix_data = 0; lat_chk = 0; rnd_req = 1; rnd_dly = 1; stray_en = 1;
    repeat (800) tick();
    rnd_req = 0; stray_en = 0;
    rv[0] = 0; rv[1] = 0; rv[2] = 0;
    repeat (12) tick();
    chk("quiesce_busy", busy, 0);

`ifdef APB_ARB_WDOG_EN
    begin
      int gcy, rcy;
      gcy = -1; rcy = -1;
      rv[0] = 1; ra[0] = 32'h700;
      for (int n = 0; n < 20; n++) begin
        if (gcy >= 0) rv[0] = 0;
        p_req_accept = 0; p_resp_valid = 0;
        #1;
        if (req_ready == 3'b001 && gcy < 0) gcy = n;
        if (resp_valid != 0 && rcy < 0) begin
          rcy = n;
          chk("wdog_resp_valid", resp_valid, 3'b001);
          chk("wdog_rdata", resp_rdata, 0);
          chk("wdog_err", resp_err, 2'b11);
        end
        @(negedge Pclk);
      end
      chk("wdog_latency", rcy - (gcy + 1), 8);
      for (int n = 0; n < 5; n++) begin
        p_resp_valid = 1; p_resp_rdata = $urandom | 32'h1; p_resp_err = 2'b01;
        #1;
        chk("stray_resp_valid", resp_valid, 0);
        chk("stray_rdata", resp_rdata, 0);
        chk("stray_err", resp_err, 2'b11);
        @(negedge Pclk);
      end
      p_resp_valid = 0;
      do_reset();
    end
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
